// File: rtl/riscv_cpu_pkg.sv
// Shared load/store definitions: FSM state type, RV32I funct3 encodings and
// request-legality helpers used by the LSU.
package riscv_cpu_pkg;

    localparam int BE_WIDTH = 4;

    typedef enum logic [1:0] {
        LSU_IDLE        = 2'd0,
        LSU_WAIT_GNT    = 2'd1,
        LSU_WAIT_RVALID = 2'd2
    } lsu_state_e;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    function automatic logic f3_legal(input logic we, input logic [2:0] f3);
        if (we)
            return (f3 == F3_SB) || (f3 == F3_SH) || (f3 == F3_SW);
        return (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
               (f3 == F3_LBU) || (f3 == F3_LHU);
    endfunction

    // size is funct3[1:0]: 0 byte, 1 half, 2 word; only meaningful for legal funct3
    function automatic logic addr_misaligned(input logic [1:0] size, input logic [1:0] lo);
        case (size)
            2'b01:   return lo[0];
            2'b10:   return lo != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_data_align.sv
// Combinational lane steering: store byte-enables and data replication,
// load byte/half extraction with sign or zero extension.
module lsu_data_align
    import riscv_cpu_pkg::*;
(
    input  logic [2:0]          funct3_i,
    input  logic [1:0]          offset_i,
    input  logic [31:0]         wdata_i,
    input  logic [31:0]         rdata_raw_i,
    output logic [BE_WIDTH-1:0] be_o,
    output logic [31:0]         wdata_o,
    output logic [31:0]         rdata_o
);

    logic [31:0] w_shifted;

    assign w_shifted = rdata_raw_i >> {offset_i, 3'b000};

    // NOTE: every output gets a default first so no path can infer a latch.
    always_comb begin
        be_o    = 4'b1111;
        wdata_o = wdata_i;
        rdata_o = w_shifted;
        case (funct3_i[1:0])
            2'b00: begin
                be_o    = 4'b0001 << offset_i;
                wdata_o = {4{wdata_i[7:0]}};
                rdata_o = funct3_i[2] ? {24'b0, w_shifted[7:0]}
                                      : {{24{w_shifted[7]}}, w_shifted[7:0]};
            end
            2'b01: begin
                be_o    = 4'b0011 << offset_i;
                wdata_o = {2{wdata_i[15:0]}};
                rdata_o = funct3_i[2] ? {16'b0, w_shifted[15:0]}
                                      : {{16{w_shifted[15]}}, w_shifted[15:0]};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/lsu_controller.sv
// Single-outstanding load/store unit: accepts an EX-stage request, runs a
// req/gnt + rvalid data-memory handshake and aborts on timeout.
module lsu_controller
    import riscv_cpu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                req_i,
    input  logic                we_i,
    input  logic [2:0]          funct3_i,
    input  logic [31:0]         addr_i,
    input  logic [31:0]         wdata_i,
    output logic                busy_o,
    output logic [31:0]         rdata_o,
    output logic                rvalid_o,
    output logic                misaligned_o,
    output logic                err_o,
    output logic                data_req_o,
    input  logic                data_gnt_i,
    output logic [31:0]         data_addr_o,
    output logic                data_we_o,
    output logic [BE_WIDTH-1:0] data_be_o,
    output logic [31:0]         data_wdata_o,
    input  logic [31:0]         data_rdata_i,
    input  logic                data_rvalid_i
);

    localparam int              CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    lsu_state_e       r_state;
    lsu_state_e       w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic             r_we;
    logic [2:0]       r_funct3;
    logic [31:0]      r_addr;
    logic [31:0]      r_wdata;
    logic             r_err;

    logic w_legal, w_misaligned, w_idle_req, w_accept, w_illegal;
    logic w_waiting, w_gnt_done, w_rv_done, w_complete, w_timeout;

    assign w_legal      = f3_legal(we_i, funct3_i);
    assign w_misaligned = w_legal && addr_misaligned(funct3_i[1:0], addr_i[1:0]);
    assign w_idle_req   = (r_state == LSU_IDLE) && req_i;
    assign w_accept     = w_idle_req && w_legal && !w_misaligned;
    assign w_illegal    = w_idle_req && !w_legal;

    assign w_waiting  = r_state != LSU_IDLE;
    assign w_gnt_done = (r_state == LSU_WAIT_GNT) && data_gnt_i;
    assign w_rv_done  = (r_state == LSU_WAIT_RVALID) && data_rvalid_i;
    assign w_complete = (w_gnt_done && r_we) || w_rv_done;
    // Completion wins: a grant or rvalid on the last allowed cycle is not a timeout.
    assign w_timeout  = w_waiting && !w_gnt_done && !w_rv_done && (r_cnt == CNT_LAST);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            LSU_IDLE: begin
                if (w_accept)
                    w_state_nxt = LSU_WAIT_GNT;
            end
            LSU_WAIT_GNT: begin
                if (data_gnt_i)
                    w_state_nxt = r_we ? LSU_IDLE : LSU_WAIT_RVALID;
                else if (w_timeout)
                    w_state_nxt = LSU_IDLE;
            end
            LSU_WAIT_RVALID: begin
                if (data_rvalid_i || w_timeout)
                    w_state_nxt = LSU_IDLE;
            end
            default: w_state_nxt = LSU_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= LSU_IDLE;
            r_cnt   <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_err   <= w_illegal || w_timeout;
            if (w_state_nxt != r_state)
                r_cnt <= '0;
            else if (w_waiting)
                r_cnt <= r_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_we     <= 1'b0;
            r_funct3 <= 3'b000;
            r_addr   <= 32'h0;
            r_wdata  <= 32'h0;
        end else if (w_accept) begin
            r_we     <= we_i;
            r_funct3 <= funct3_i;
            r_addr   <= addr_i;
            r_wdata  <= wdata_i;
        end
    end

    lsu_data_align u_align (
        .funct3_i    (r_funct3),
        .offset_i    (r_addr[1:0]),
        .wdata_i     (r_wdata),
        .rdata_raw_i (data_rdata_i),
        .be_o        (data_be_o),
        .wdata_o     (data_wdata_o),
        .rdata_o     (rdata_o)
    );

    assign data_req_o   = r_state == LSU_WAIT_GNT;
    assign data_addr_o  = {r_addr[31:2], 2'b00};
    assign data_we_o    = r_we;
    assign rvalid_o     = w_rv_done;
    assign err_o        = r_err;
    assign misaligned_o = w_idle_req && w_misaligned;
    // The acceptance term is gated so busy_o stays low while reset is held.
    assign busy_o       = !rst_i && (w_accept || (w_waiting && !w_complete && !w_timeout));

endmodule

// File: tb/tb_lsu_controller.sv
// Scoreboard bench for lsu_controller: directed corner cases plus random
// transactions checked against a byte-lane reference model.
module tb_lsu_controller;

    localparam int TO = 4;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        req_i, we_i;
    logic [2:0]  funct3_i;
    logic [31:0] addr_i, wdata_i;
    logic        busy_o, rvalid_o, misaligned_o, err_o;
    logic [31:0] rdata_o;
    logic        data_req_o, data_gnt_i, data_we_o, data_rvalid_i;
    logic [31:0] data_addr_o, data_wdata_o, data_rdata_i;
    logic [3:0]  data_be_o;

    lsu_controller #(.TIMEOUT_CYCLES(TO)) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .req_i         (req_i),
        .we_i          (we_i),
        .funct3_i      (funct3_i),
        .addr_i        (addr_i),
        .wdata_i       (wdata_i),
        .busy_o        (busy_o),
        .rdata_o       (rdata_o),
        .rvalid_o      (rvalid_o),
        .misaligned_o  (misaligned_o),
        .err_o         (err_o),
        .data_req_o    (data_req_o),
        .data_gnt_i    (data_gnt_i),
        .data_addr_o   (data_addr_o),
        .data_we_o     (data_we_o),
        .data_be_o     (data_be_o),
        .data_wdata_o  (data_wdata_o),
        .data_rdata_i  (data_rdata_i),
        .data_rvalid_i (data_rvalid_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
    } mem_t;

    mem_t        mem_q[$];
    logic [31:0] rd_q[$];
    int          exp_err = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    logic [31:0] last_addr, last_wdata, last_rdata;
    logic [3:0]  last_be;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int m_size(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   return 1;
            2'b01:   return 2;
            default: return 4;
        endcase
    endfunction

    function automatic bit m_legal(input logic we, input logic [2:0] f3);
        if (we) return f3 <= 3'd2;
        return f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    endfunction

    function automatic bit m_misaligned(input logic [2:0] f3, input logic [31:0] addr);
        return (addr % m_size(f3)) != 0;
    endfunction

    function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] addr);
        int off = int'(addr % 4);
        logic [3:0] be = '0;
        for (int i = 0; i < 4; i++)
            if (i >= off && i < off + m_size(f3)) be[i] = 1'b1;
        return be;
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] wd);
        logic [31:0] r;
        for (int i = 0; i < 4; i++)
            r[8*i +: 8] = wd[8*(i % m_size(f3)) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] m_rdata(input logic [2:0] f3, input logic [31:0] addr,
                                            input logic [31:0] raw);
        int n = m_size(f3);
        logic [31:0] sh, mask, val;
        sh = raw >> (8 * (addr % 4));
        if (n == 4) return sh;
        mask = (32'd1 << (8 * n)) - 32'd1;
        val  = sh & mask;
        if (!f3[2] && val[8*n-1]) val = val | ~mask;
        return val;
    endfunction

    // ---------------- monitor ----------------
    initial begin : monitor
        bit req_pending = 0;
        forever @(negedge clk_i) begin
            if (data_req_o) begin
                if (mem_q.size() == 0) begin
                    check("unexpected_data_req", data_req_o, 1'b0);
                end else begin
                    check("mem_addr",  data_addr_o,  mem_q[0].addr);
                    check("mem_we",    data_we_o,    mem_q[0].we);
                    check("mem_be",    data_be_o,    mem_q[0].be);
                    if (mem_q[0].we) check("mem_wdata", data_wdata_o, mem_q[0].wdata);
                    if (data_gnt_i) begin
                        last_addr  = data_addr_o;
                        last_be    = data_be_o;
                        last_wdata = data_wdata_o;
                        void'(mem_q.pop_front());
                        req_pending = 0;
                    end else begin
                        req_pending = 1;
                    end
                end
            end else if (req_pending) begin
                // request withdrawn without grant (timeout or reset)
                if (mem_q.size() != 0) void'(mem_q.pop_front());
                req_pending = 0;
            end
            if (rvalid_o) begin
                if (rd_q.size() == 0) begin
                    check("unexpected_rvalid", rvalid_o, 1'b0);
                end else begin
                    check("load_rdata", rdata_o, rd_q.pop_front());
                    last_rdata = rdata_o;
                end
            end
            if (err_o) begin
                if (exp_err == 0) check("unexpected_err", err_o, 1'b0);
                else exp_err--;
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // ---------------- drivers ----------------
    task automatic drive_junk(input logic keep_req);
        req_i    = keep_req;
        we_i     = 1'($urandom_range(0, 1));
        funct3_i = 3'($urandom);
        addr_i   = $urandom;
        wdata_i  = $urandom;
    endtask

    // Entered and left at posedge+1 with the FSM in IDLE.
    task automatic run_txn(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wd, input int gd, input int rd,
                           input logic [31:0] raw);
        bit legal = m_legal(we, f3);
        bit mis   = legal && m_misaligned(f3, addr);
        bit to_g  = gd >= TO;
        bit to_r  = rd >= TO;
        req_i = 1'b1; we_i = we; funct3_i = f3; addr_i = addr; wdata_i = wd;
        data_gnt_i = 1'b0; data_rvalid_i = 1'b0;
        @(negedge clk_i);
        if (!legal) begin
            check("illegal_busy", busy_o, 1'b0);
            check("illegal_misaligned", misaligned_o, 1'b0);
            exp_err++;
            @(posedge clk_i); #1 req_i = 1'b0;
            @(negedge clk_i);
            check("illegal_err", err_o, 1'b1);
            check("illegal_no_req", data_req_o, 1'b0);
            @(posedge clk_i); #1;
            return;
        end
        if (mis) begin
            check("misaligned_flag", misaligned_o, 1'b1);
            check("misaligned_busy", busy_o, 1'b0);
            @(posedge clk_i); #1 req_i = 1'b0;
            @(negedge clk_i);
            check("misaligned_no_req", data_req_o, 1'b0);
            @(posedge clk_i); #1;
            return;
        end
        check("accept_busy", busy_o, 1'b1);
        check("accept_misaligned", misaligned_o, 1'b0);
        mem_q.push_back('{addr: {addr[31:2], 2'b00}, we: we, be: m_be(f3, addr),
                          wdata: m_wdata(f3, wd)});
        @(posedge clk_i); #1;
        for (int c = 0; c < TO; c++) begin
            bit gnt  = (c == gd);
            bit last = gnt || (c == TO - 1);
            drive_junk(!(last && (we || !gnt)));
            data_gnt_i    = gnt;
            data_rvalid_i = 1'($urandom_range(0, 1));
            data_rdata_i  = $urandom;
            @(negedge clk_i);
            check("gnt_phase_req", data_req_o, 1'b1);
            check("gnt_phase_busy", busy_o, ((gnt && we) || (!gnt && c == TO - 1)) ? 1'b0 : 1'b1);
            check("gnt_phase_no_rvalid", rvalid_o, 1'b0);
            @(posedge clk_i); #1;
            if (last) break;
        end
        data_gnt_i = 1'b0; data_rvalid_i = 1'b0;
        if (to_g) begin
            exp_err++;
            @(negedge clk_i);
            check("gnt_timeout_err", err_o, 1'b1);
            check("gnt_timeout_req", data_req_o, 1'b0);
            check("gnt_timeout_busy", busy_o, 1'b0);
            @(posedge clk_i); #1;
            return;
        end
        if (we) return;
        if (!to_r) rd_q.push_back(m_rdata(f3, addr, raw));
        for (int c = 0; c < TO; c++) begin
            bit rv   = (c == rd);
            bit last = rv || (c == TO - 1);
            drive_junk(!last);
            data_gnt_i    = 1'b0;
            data_rvalid_i = rv;
            data_rdata_i  = rv ? raw : $urandom;
            @(negedge clk_i);
            check("rv_phase_no_req", data_req_o, 1'b0);
            check("rv_phase_busy", busy_o, last ? 1'b0 : 1'b1);
            check("rv_phase_rvalid", rvalid_o, rv);
            @(posedge clk_i); #1;
            if (last) break;
        end
        data_rvalid_i = 1'b0;
        if (to_r) begin
            exp_err++;
            @(negedge clk_i);
            check("rv_timeout_err", err_o, 1'b1);
            check("rv_timeout_busy", busy_o, 1'b0);
            @(posedge clk_i); #1;
        end
    endtask

    task automatic reset_tests();
        // Reset while waiting for rvalid; the late rvalid must be ignored.
        req_i = 1'b1; we_i = 1'b0; funct3_i = 3'd2; addr_i = 32'h200; wdata_i = 32'h0;
        @(negedge clk_i);
        mem_q.push_back('{addr: 32'h200, we: 1'b0, be: 4'hF, wdata: 32'h0});
        @(posedge clk_i); #1 req_i = 1'b0; data_gnt_i = 1'b1;
        @(posedge clk_i); #1 data_gnt_i = 1'b0;
        #3 rst_i = 1'b1;
        #1;
        check("rst_rv_req", data_req_o, 1'b0);
        check("rst_rv_busy", busy_o, 1'b0);
        check("rst_rv_rvalid", rvalid_o, 1'b0);
        @(posedge clk_i); #1 rst_i = 1'b0;
        data_rvalid_i = 1'b1; data_rdata_i = 32'h1234_5678;
        @(negedge clk_i);
        check("post_rst_no_rvalid", rvalid_o, 1'b0);
        check("post_rst_busy", busy_o, 1'b0);
        @(posedge clk_i); #1 data_rvalid_i = 1'b0;

        // Reset while requesting; data_req_o must fall without a clock edge.
        req_i = 1'b1; we_i = 1'b1; funct3_i = 3'd2; addr_i = 32'h300; wdata_i = 32'hCAFE_F00D;
        @(negedge clk_i);
        mem_q.push_back('{addr: 32'h300, we: 1'b1, be: 4'hF, wdata: 32'hCAFE_F00D});
        @(posedge clk_i); #1 req_i = 1'b0;
        @(negedge clk_i); #2 rst_i = 1'b1;
        #1;
        check("rst_async_req_drop", data_req_o, 1'b0);
        check("rst_async_busy", busy_o, 1'b0);
        @(posedge clk_i); #1 rst_i = 1'b0;
        @(posedge clk_i); #1;
    endtask

    // ---------------- main sequence ----------------
    initial begin : stim
        rst_i = 1'b1;
        req_i = 1'b1; we_i = 1'b1; funct3_i = 3'd2; addr_i = 32'h40; wdata_i = 32'h1;
        data_gnt_i = 1'b0; data_rvalid_i = 1'b0; data_rdata_i = 32'h0;
        last_addr = '0; last_wdata = '0; last_rdata = '0; last_be = '0;
        repeat (2) @(negedge clk_i);
        check("reset_busy", busy_o, 1'b0);
        check("reset_data_req", data_req_o, 1'b0);
        check("reset_rvalid", rvalid_o, 1'b0);
        check("reset_err", err_o, 1'b0);
        @(posedge clk_i); #1 rst_i = 1'b0; req_i = 1'b0;
        @(posedge clk_i); #1;

        run_txn(1'b1, 3'd2, 32'h100, 32'hDEAD_BEEF, 2, 0, 32'h0);
        check("sw_be", last_be, 4'b1111);
        check("sw_addr", last_addr, 32'h100);
        check("sw_wdata", last_wdata, 32'hDEAD_BEEF);

        run_txn(1'b0, 3'd0, 32'h103, 32'h0, 1, 1, 32'h80FF_FF11);
        check("lb_rdata", last_rdata, 32'hFFFF_FF80);
        run_txn(1'b0, 3'd4, 32'h103, 32'h0, 0, 2, 32'h80FF_FF11);
        check("lbu_rdata", last_rdata, 32'h0000_0080);

        run_txn(1'b1, 3'd1, 32'h102, 32'h1234_ABCD, 0, 0, 32'h0);
        check("sh_be", last_be, 4'b1100);
        check("sh_wdata", last_wdata, 32'hABCD_ABCD);

        run_txn(1'b0, 3'd2, 32'h101, 32'h0, 0, 0, 32'h0);       // misaligned LW
        run_txn(1'b0, 3'd2, 32'h180, 32'h0, 99, 0, 32'h0);      // no grant -> timeout
        run_txn(1'b0, 3'd5, 32'h1C2, 32'h0, 0, 99, 32'hBEEF_8001); // no rvalid -> timeout
        run_txn(1'b0, 3'd1, 32'h1C6, 32'h0, TO - 1, TO - 1, 32'h8001_7FFF); // completion on last cycle
        run_txn(1'b1, 3'd2, 32'h1D0, 32'h5, TO - 1, 0, 32'h0);
        run_txn(1'b0, 3'd3, 32'h0, 32'h0, 0, 0, 32'h0);         // illegal load funct3
        run_txn(1'b1, 3'd4, 32'h0, 32'h0, 0, 0, 32'h0);         // illegal store funct3

        reset_tests();

        for (int i = 0; i < 60; i++) begin
            logic        we   = 1'($urandom_range(0, 1));
            logic [2:0]  f3;
            logic [31:0] addr = $urandom;
            if ($urandom_range(0, 4) == 0) f3 = 3'($urandom);
            else if (we)                   f3 = 3'($urandom_range(0, 2));
            else                           f3 = ($urandom_range(0, 1) == 1) ? 3'($urandom_range(0, 2))
                                                                             : 3'($urandom_range(4, 5));
            if ($urandom_range(0, 2) != 0) addr = addr & ~32'(m_size(f3) - 1);
            run_txn(we, f3, addr, $urandom, $urandom_range(0, 5), $urandom_range(0, 5), $urandom);
        end

        req_i = 1'b0;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        check("end_mem_q_empty", 32'(mem_q.size()), 32'd0);
        check("end_rd_q_empty", 32'(rd_q.size()), 32'd0);
        check("end_err_all_seen", 32'(exp_err), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/lsu_controller.md
LSU_CONTROLLER -- requirements
Module: lsu_controller

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 16, the maximum cycles spent waiting in either wait state before aborting.
REQ-002 The block SHALL have port clk_i, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_i, input, 1, reset, asynchronous and active-high.
REQ-004 The block SHALL have port req_i, input, 1, EX-stage load/store request valid.
REQ-005 The block SHALL have port we_i, input, 1, 1 = store, 0 = load.
REQ-006 The block SHALL have port funct3_i, input, 3, RV32I load/store width and sign encoding.
REQ-007 The block SHALL have port addr_i, input, 32, byte address (ALU result).
REQ-008 The block SHALL have port wdata_i, input, 32, store data (rs2).
REQ-009 The block SHALL have port busy_o, output, 1, pipeline stall request.
REQ-010 The block SHALL have port rdata_o, output, 32, aligned and extended load result.
REQ-011 The block SHALL have port rvalid_o, output, 1, rdata_o valid, 1-cycle pulse.
REQ-012 The block SHALL have port misaligned_o, output, 1, combinational misaligned-access flag.
REQ-013 The block SHALL have port err_o, output, 1, registered 1-cycle pulse for timeout or illegal funct3.
REQ-014 The block SHALL have the following data-memory ports: data_req_o out 1; data_gnt_i in 1; data_addr_o out 32; data_we_o out 1; data_be_o out 4; data_wdata_o out 32; data_rdata_i in 32; data_rvalid_i in 1.

Function
REQ-015 The FSM SHALL have exactly three states, IDLE, WAIT_GNT and WAIT_RVALID.
REQ-016 Acceptance SHALL be defined as: in IDLE, when req_i=1 with a legal funct3 and an aligned address, the block captures we, funct3, addr and wdata, and moves to WAIT_GNT.
REQ-017 Illegal funct3 SHALL be loads 3, 6 and 7, and stores 3 and above; in that case the block starts no transaction, stays in IDLE, and pulses err_o on the next cycle.
REQ-018 Misalignment SHALL be defined as LH/LHU/SH with addr_i[0]=1, or LW/SW with addr_i[1:0]≠0; in that case misaligned_o=1 in the same cycle, no transaction starts, and busy_o=0.
REQ-019 data_req_o SHALL be 1 exactly while in WAIT_GNT; first assertion is the cycle after acceptance.
REQ-020 data_addr_o, data_we_o, data_be_o and data_wdata_o SHALL be driven from the captured values and held stable while data_req_o=1.
REQ-021 data_addr_o SHALL be {addr[31:2],2'b00}.
REQ-022 data_be_o SHALL be: SB 4'b0001<<addr[1:0]; SH 4'b0011<<addr[1:0]; SW 4'b1111.
REQ-023 data_wdata_o SHALL be: SB {4{wdata[7:0]}}; SH {2{wdata[15:0]}}; SW wdata.
REQ-024 On WAIT_GNT with data_gnt_i=1, a store SHALL return to IDLE and a load SHALL move to WAIT_RVALID.
REQ-025 On WAIT_RVALID with data_rvalid_i=1, rvalid_o SHALL be 1 in the same cycle and the FSM SHALL return to IDLE.
REQ-026 rdata_o SHALL be data_rdata_i shifted right by 8·addr[1:0], then sign-extended for LB/LH or zero-extended for LBU/LHU; LW passes through.
REQ-027 busy_o SHALL be 1 on the acceptance cycle and in all non-IDLE cycles, except the completion cycle (store grant or load rvalid), where it is 0.
REQ-028 req_i SHALL be ignored outside IDLE.
REQ-029 data_rvalid_i in IDLE or WAIT_GNT SHALL be ignored.
REQ-030 A timeout counter SHALL clear on entry to each wait state and increment on every cycle spent waiting.
REQ-031 When the timeout counter reaches TIMEOUT_CYCLES, the block SHALL go to IDLE, drop data_req_o, pulse err_o for one cycle, and set busy_o=0 that cycle.
REQ-032 Completion SHALL take priority over timeout when both occur in the same cycle.

Reset
REQ-033 While rst_i=1, the FSM SHALL be in IDLE, the counter SHALL be 0, and data_req_o, rvalid_o, err_o and busy_o SHALL all be 0.
REQ-034 Captured request registers SHALL reset to 0.
REQ-035 data_req_o SHALL drop asynchronously on reset.
REQ-036 A data_rvalid_i arriving after a reset that occurred mid-transaction SHALL be ignored.

Structure
REQ-037 riscv_cpu_pkg SHALL hold lsu_state_e, the LB/LH/LW/LBU/LHU/SB/SH/SW funct3 constants, and BE_WIDTH=4.
REQ-038 Byte-enable, store-data replication and load extraction/extension SHALL reside in one combinational sub-module, lsu_data_align.

Verification
REQ-039 The bench SHALL cover SW to addr 0x100, data 0xDEADBEEF, gnt after 2 cycles -> data_be_o=1111, data_addr_o=0x100, busy_o 0 on the gnt cycle, no rvalid_o.
REQ-040 The bench SHALL cover LB at addr 0x103 with data_rdata_i=0x80FF_FF11 -> rdata_o=0xFFFFFF80, rvalid_o pulse; LBU at the same address -> 0x00000080.
REQ-041 The bench SHALL cover SH to 0x102 with wdata_i=0x1234ABCD -> data_be_o=1100, data_wdata_o=0xABCDABCD.
REQ-042 The bench SHALL cover LW at 0x101 -> misaligned_o=1 in the same cycle, data_req_o stays 0, busy_o=0.
REQ-043 The bench SHALL cover a load with gnt never asserted, TIMEOUT_CYCLES=4 -> err_o pulse after 4 waiting cycles, FSM IDLE, data_req_o=0.
REQ-044 The bench SHALL cover rst_i asserted in WAIT_RVALID, then data_rvalid_i after release -> no rvalid_o, busy_o=0.
